uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states,
// baud-select encodings and parity-type constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] BAUD_9600 = 2'b00;
    localparam logic [1:0] BAUD_4800 = 2'b01;
    localparam logic [1:0] BAUD_2400 = 2'b10;
    localparam logic [1:0] BAUD_1200 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (odd == PARITY_EVEN) ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Rising-edge detector on all four baud square waves plus the rate mux.
// History is kept for every rate so switching the select never fakes an edge.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       T9600,
    input  logic       T4800,
    input  logic       T2400,
    input  logic       T1200,
    input  logic [1:0] baud_sel,
    output logic       tick
);

    logic [3:0] level;
    logic [3:0] prev;
    logic [3:0] tick_r;

    assign level = {T1200, T2400, T4800, T9600};

    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= 4'b0000;
            tick_r <= 4'b0000;
        end else begin
            prev   <= level;
            tick_r <= level & ~prev;
        end
    end

    always_comb begin
        tick = 1'b0;
        case (baud_sel)
            BAUD_9600: tick = tick_r[0];
            BAUD_4800: tick = tick_r[1];
            BAUD_2400: tick = tick_r[2];
            BAUD_1200: tick = tick_r[3];
            default:   tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One byte in flight; tx_ready is high only in IDLE, so tx_valid is simply held off while busy.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       T9600,
    input  logic       T4800,
    input  logic       T2400,
    input  logic       T1200,
    input  logic [1:0] baud_sel,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t  state, state_n;
    logic       tx_q, tx_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       stop_cnt, stop_cnt_n;
    logic [7:0] data_q, data_n;
    logic [1:0] sel_q, sel_n;
    logic       pe_q, pe_n;
    logic       po_q, po_n;
    logic       tick;

    // Ticks follow the select latched at accept, not the live input.
    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .T9600    (T9600),
        .T4800    (T4800),
        .T2400    (T2400),
        .T1200    (T1200),
        .baud_sel (sel_q),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_q     <= 1'b1;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            data_q   <= 8'h00;
            sel_q    <= 2'b00;
            pe_q     <= 1'b0;
            po_q     <= 1'b0;
        end else begin
            state    <= state_n;
            tx_q     <= tx_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            data_q   <= data_n;
            sel_q    <= sel_n;
            pe_q     <= pe_n;
            po_q     <= po_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx_q;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        data_n     = data_q;
        sel_n      = sel_q;
        pe_n       = pe_q;
        po_n       = po_q;
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (tx_valid) begin
                    data_n  = tx_data;
                    sel_n   = baud_sel;
                    pe_n    = parity_en;
                    po_n    = parity_odd;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    tx_n    = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_n      = data_q[0];
                    bit_cnt_n = 3'd0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = data_q[bit_cnt + 3'd1];
                    end else if (pe_q) begin
                        tx_n    = parity_bit(data_q, po_q);
                        state_n = ST_PARITY;
                    end else begin
                        tx_n       = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_n = ST_IDLE;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = ~tx_ready;

endmodule
